ahb_ram_slave: RTL and testbench
================================

# ahb_ram_slave

AHB-Lite responder for the RAM region (0xB000_0000) of the SoC data bus. It captures address-phase controls, inserts a configurable number of wait states, and commits byte/halfword/word writes with per-lane strobes. It returns full 32-bit read words and issues the two-cycle AHB ERROR response for illegal transfers. It is the slave-side counterpart of the core's master glue logic, sitting behind the bus decoder's HSEL for the RAM region.

## Interface
Parameters:
- ADDR_BASE, 32'hB000_0000: base of the RAM region; decoding uses haddr[31:24] against ADDR_BASE[31:24].
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array. Must be a power of 2.
- WAIT_STATES, 0: extra data-phase cycles (0..7) that hreadyout is held low on OKAY transfers.

Ports:
- hclk  in  1  bus clock; single clock domain.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the address decoder.
- haddr  in  32  transfer address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  000 byte, 001 halfword, 010 word.
- hprot  in  4  protection; accepted and ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-wide ready, used for address-phase qualification.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data.

## Operation
- **Transfer accept.** An address phase is accepted on a rising hclk when hsel && hready && htrans[1]. On accept, the block registers haddr, hwrite, hsize and a legality flag.
- **IDLE/BUSY transfers.** When selected, these get a zero-wait OKAY response. No data phase is created for them.
- **Illegal transfers.** Any of the following is illegal:
  - hsize > 010
  - halfword with haddr[0] = 1
  - word with haddr[1:0] != 00
  - haddr[31:24] != ADDR_BASE[31:24]
  - word index haddr[31:2] - ADDR_BASE[31:2] >= DEPTH_WORDS
- **Byte strobes** (little-endian):
  - byte → 4'b0001 << haddr[1:0]
  - halfword → 4'b0011 << {haddr[1],1'b0}
  - word → 4'b1111
- **Writes.** Only strobed lanes of the addressed word are updated from hwdata. The write commits on the edge that completes the data phase (hreadyout = 1). Illegal transfers never write.
- **Reads.** hrdata returns the full addressed word; the master performs lane extraction and sign extension. hrdata is 0 in every cycle that is not a completing OKAY read.
- **State machine.** States are IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT: legal accept with WAIT_STATES > 0; the wait counter loads WAIT_STATES.
  - IDLE stays IDLE: legal accept with WAIT_STATES = 0. The data phase completes in the next cycle with hreadyout = 1.
  - WAIT: hreadyout = 0 while the counter decrements. At counter = 1, it moves to a completion cycle with hreadyout = 1, then returns to IDLE. If a new legal accept occurs in that completion cycle, the counter reloads and it re-enters WAIT.
  - Illegal accept → ERR1 (hreadyout = 0, hresp = 1) → ERR2 (hreadyout = 1, hresp = 1) → IDLE.
  - Accepts during ERR2 are honoured (pipelined), per AHB.
- **Back-to-back pipelining.** A new address phase overlaps the previous data phase. A read immediately following a write to the same word returns the newly written data; the write-then-read forwarding is satisfied by array ordering, with no stale read.

## Timing
- **Reset values.** hreadyout = 1, hresp = 0, hrdata = 0, state IDLE, wait counter 0. Array contents are not reset.
- **Reset mid-transfer.** Asserting hresetn = 0 during WAIT/ERR1/ERR2 aborts the transfer with no array write, and outputs take their reset values immediately (asynchronously).
- **OKAY latency.** Data-phase length is 1 + WAIT_STATES cycles. Read data is valid in the last cycle only.
- **ERROR latency.** The response is exactly 2 cycles regardless of WAIT_STATES.
- **hresp.** hresp = 1 only in ERR1 and ERR2.
- **Unselected slave.** Outputs remain hreadyout = 1 and hresp = 0 while the slave is not selected.

## Structure
- **Package ahb_pkg** holds:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_e (BYTE, HALF, WORD)
  - HRESP_OKAY / HRESP_ERROR constants
  - the slave state enum
- **Sub-module ahb_byte_lane_decode** is combinational: (hsize, haddr[1:0]) → strb[3:0] and misaligned. It is reusable by the ROM slave.

## Test plan
- **Zero-wait word write/read** (WAIT_STATES = 0): write 0xDEADBEEF to 0xB000_0010, then read it back → read data phase returns 0xDEADBEEF, hreadyout = 1 in every cycle, hresp = 0.
- **Byte write preserves other lanes:** word 0x11223344 at 0xB000_0020, then SB 0xAA to 0xB000_0021 → readback 0x1122AA44.
- **Wait states** (WAIT_STATES = 3): NONSEQ read → hreadyout low for exactly 3 cycles, with data valid on the 4th.
- **Misaligned write:** SW to 0xB000_0002 with hwdata 0xFFFFFFFF → ERR1 (hreadyout = 0, hresp = 1) then ERR2 (hreadyout = 1, hresp = 1). A subsequent read of 0xB000_0000 returns the prior value.
- **Out-of-range access:** read at 0xB000_0000 + 4*DEPTH_WORDS → ERROR response. A BUSY transfer gets a zero-wait OKAY.
- **Reset mid-WAIT:** assert hresetn low in the 2nd wait cycle of a write → outputs reset immediately and the target word is unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings and slave state type
// No ports; imported by the AHB slave modules.
package ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_e;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} slv_state_e;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ahb_byte_lane_decode: little-endian byte strobes and alignment check from hsize/haddr[1:0]
// hsize: transfer size; addr: haddr[1:0]; strb: active byte lanes; misaligned: halfword/word alignment violation
module ahb_byte_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       misaligned
);
  always_comb begin
    strb = hsize == SZ_BYTE ? 4'b0001 << addr : hsize == SZ_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    misaligned = (hsize == SZ_HALF && addr[0]) || (hsize == SZ_WORD && addr != 2'b00);
  end
endmodule

// File: rtl/ahb_ram_slave.sv
// ahb_ram_slave: AHB-Lite RAM responder with wait states, byte-lane writes and two-cycle ERROR
// hclk/hresetn: clock and asynchronous active-low reset
// hsel/haddr/htrans/hwrite/hsize/hprot/hwdata/hready: AHB-Lite slave inputs (hprot ignored)
// hreadyout/hresp/hrdata: slave response; hrdata is non-zero only in a completing OKAY read
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'hB000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  localparam int AW = $clog2(DEPTH_WORDS);
  slv_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] strb, dp_strb;
  logic mis, legal, acc, done, dp_act, dp_write, unused;
  logic [31:0] off;
  logic [AW-1:0] dp_idx;
  logic [31:0] mem [DEPTH_WORDS];

  ahb_byte_lane_decode u_dec (.hsize(hsize), .addr(haddr[1:0]), .strb(strb), .misaligned(mis));

  assign off = {2'b00, haddr[31:2] - ADDR_BASE[31:2]};
  assign legal = hsize <= SZ_WORD && !mis && haddr[31:24] == ADDR_BASE[31:24] && off < DEPTH_WORDS;
  assign acc = hsel && hready && htrans[1];
  assign hreadyout = state != ST_WAIT && state != ST_ERR1;
  assign hresp = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
  // a pending legal data phase completes in any cycle where we drive ready
  assign done = dp_act && hreadyout;
  assign hrdata = done && !dp_write ? mem[dp_idx] : '0;
  assign unused = ^hprot;

  // accepts are only possible while ready; WAIT/ERR1 ignore the address bus
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == ST_WAIT) begin
      state_n = cnt == 3'd1 ? ST_IDLE : ST_WAIT;
      cnt_n = cnt - 3'd1;
    end else if (state == ST_ERR1) begin
      state_n = ST_ERR2;
    end else if (acc) begin
      state_n = !legal ? ST_ERR1 : WAIT_STATES != 0 ? ST_WAIT : ST_IDLE;
      cnt_n = legal ? 3'(WAIT_STATES) : 3'd0;
    end else begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt <= '0;
      dp_act <= 1'b0;
      dp_write <= 1'b0;
      dp_strb <= '0;
      dp_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (hreadyout) begin
        dp_act <= acc && legal;
        dp_write <= hwrite;
        dp_strb <= strb;
        dp_idx <= off[AW-1:0];
      end
    end
  end

  // array ordering gives write-then-read forwarding: the write lands before the next data phase reads
  always_ff @(posedge hclk) begin
    if (done && dp_write)
      for (int i = 0; i < 4; i++)
        if (dp_strb[i]) mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_ram_slave.sv
// tb_ahb_ram_slave: directed checks of zero-wait and three-wait-state RAM slave instances
module tb_ahb_ram_slave;
  logic hclk = 1'b0, hresetn = 1'b0, hsel = 1'b0, hwrite = 1'b0, use3 = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hsize = '0;
  logic [3:0] hprot = 4'b0011;
  logic ro0, rp0, ro3, rp3, ro, rp;
  logic [31:0] rd0, rd3, rdat;
  int vectors = 0, errors = 0;

  always #5 hclk = ~hclk;

  ahb_ram_slave #(.WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel && !use3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(ro0),
    .hreadyout(ro0), .hresp(rp0), .hrdata(rd0));
  ahb_ram_slave #(.WAIT_STATES(3)) u3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel && use3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(ro3),
    .hreadyout(ro3), .hresp(rp3), .hrdata(rd3));

  assign ro = use3 ? ro3 : ro0;
  assign rp = use3 ? rp3 : rp0;
  assign rdat = use3 ? rd3 : rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits, output logic e1, output logic rsp);
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = wd;
    waits = 0; e1 = 1'b0; rd = '0; rsp = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge hclk);
      if (ro) begin
        rd = rdat; rsp = rp;
        @(posedge hclk); #1;
        return;
      end
      if (waits == 0) e1 = rp;
      waits++;
      @(posedge hclk); #1;
    end
    check("xfer_done", 32'(ro), 32'd1);
  endtask

  task automatic wr(input string t, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input int ew);
    logic [31:0] r; int w; logic e1, rsp;
    xfer(a, 1'b1, sz, d, r, w, e1, rsp);
    check({t, " waits"}, 32'(w), 32'(ew));
    check({t, " resp"}, 32'(rsp), 32'd0);
    check({t, " rdata"}, r, 32'd0);
  endtask

  task automatic rd(input string t, input logic [31:0] a, input logic [31:0] exp, input int ew);
    logic [31:0] r; int w; logic e1, rsp;
    xfer(a, 1'b0, 3'd2, 32'd0, r, w, e1, rsp);
    check({t, " waits"}, 32'(w), 32'(ew));
    check({t, " resp"}, 32'(rsp), 32'd0);
    check({t, " data"}, r, exp);
  endtask

  task automatic er(input string t, input logic [31:0] a, input logic w, input logic [2:0] sz);
    logic [31:0] r; int n; logic e1, rsp;
    xfer(a, w, sz, 32'hFFFF_FFFF, r, n, e1, rsp);
    check({t, " err1 cycles"}, 32'(n), 32'd1);
    check({t, " err1 resp"}, 32'(e1), 32'd1);
    check({t, " err2 resp"}, 32'(rsp), 32'd1);
    check({t, " rdata"}, r, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    check("rst ready0", 32'(ro0), 32'd1);
    check("rst resp0", 32'(rp0), 32'd0);
    check("rst rdata0", rd0, 32'd0);
    check("rst ready3", 32'(ro3), 32'd1);
    check("rst resp3", 32'(rp3), 32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b10; haddr = 32'hB000_0000;
    @(posedge hclk); #1;
    @(negedge hclk);
    check("unsel ready", 32'(ro0), 32'd1);
    check("unsel resp", 32'(rp0), 32'd0);
    @(posedge hclk); #1;
    htrans = 2'b00;

    wr("w0 word", 32'hB000_0010, 3'd2, 32'hDEAD_BEEF, 0);
    rd("r0 word", 32'hB000_0010, 32'hDEAD_BEEF, 0);
    wr("w0 base", 32'hB000_0020, 3'd2, 32'h1122_3344, 0);
    wr("w0 byte", 32'hB000_0021, 3'd0, 32'hAAAA_AAAA, 0);
    rd("r0 byte", 32'hB000_0020, 32'h1122_AA44, 0);
    wr("w0 half", 32'hB000_0022, 3'd1, 32'hBEEF_BEEF, 0);
    rd("r0 half", 32'hB000_0020, 32'hBEEF_AA44, 0);
    wr("w0 last", 32'hB000_0FFC, 3'd2, 32'hCAFE_F00D, 0);
    rd("r0 last", 32'hB000_0FFC, 32'hCAFE_F00D, 0);
    wr("w0 zero", 32'hB000_0000, 3'd2, 32'h5566_7788, 0);
    er("e0 misaligned sw", 32'hB000_0002, 1'b1, 3'd2);
    rd("r0 after err", 32'hB000_0000, 32'h5566_7788, 0);
    er("e0 out of range", 32'hB000_1000, 1'b0, 3'd2);
    er("e0 wrong region", 32'hA000_0000, 1'b0, 3'd2);
    er("e0 odd half", 32'hB000_0021, 1'b1, 3'd1);
    er("e0 size 3", 32'hB000_0000, 1'b1, 3'd3);
    rd("r0 still", 32'hB000_0000, 32'h5566_7788, 0);

    hsel = 1'b1; htrans = 2'b01; haddr = 32'hB000_0000; hwrite = 1'b1;
    @(negedge hclk);
    check("busy ready", 32'(ro0), 32'd1);
    check("busy resp", 32'(rp0), 32'd0);
    @(posedge hclk); #1;
    @(negedge hclk);
    check("busy after ready", 32'(ro0), 32'd1);
    check("busy after rdata", rd0, 32'd0);
    @(posedge hclk); #1;
    htrans = 2'b00;

    haddr = 32'hB000_0030; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h0BAD_CAFE; hwrite = 1'b0; htrans = 2'b10;
    @(negedge hclk);
    check("pipe w ready", 32'(ro0), 32'd1);
    check("pipe w rdata", rd0, 32'd0);
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(negedge hclk);
    check("pipe r ready", 32'(ro0), 32'd1);
    check("pipe r data", rd0, 32'h0BAD_CAFE);
    @(posedge hclk); #1;

    use3 = 1'b1;
    wr("w3 word", 32'hB000_0040, 3'd2, 32'h1234_5678, 3);
    rd("r3 word", 32'hB000_0040, 32'h1234_5678, 3);
    er("e3 misaligned", 32'hB000_0041, 1'b0, 3'd2);

    haddr = 32'hB000_0040; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check("rstw wait1", 32'(ro3), 32'd0);
    @(posedge hclk); #1;
    check("rstw wait2", 32'(ro3), 32'd0);
    hresetn = 1'b0;
    #1;
    check("rstw ready", 32'(ro3), 32'd1);
    check("rstw resp", 32'(rp3), 32'd0);
    check("rstw rdata", rd3, 32'd0);
    @(posedge hclk);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    rd("r3 after rst", 32'hB000_0040, 32'h1234_5678, 3);
    use3 = 1'b0;
    rd("r0 after rst", 32'hB000_0010, 32'hDEAD_BEEF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
